// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the CPU sequencer, its branch unit and the decoder-facing bus.
package cpu_pkg;

    localparam int unsigned PcWDefault = 8;
    localparam int unsigned InstW      = 16;
    localparam int unsigned OffW       = 6;

    // Sequencer FSM states, also exported on the debug state output.
    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    // Branch select codes produced by the decoder; 100..111 never branch.
    typedef enum logic [2:0] {
        BsBeq  = 3'b000,
        BsBne  = 3'b001,
        BsBltz = 3'b010,
        BsBgez = 3'b011,
        BsNone = 3'b100
    } bs_e;

    // Opcode field is inst[15:12]; R-type function field is inst[2:0].
    localparam logic [3:0] OpcRtype  = 4'h0;
    localparam logic [3:0] OpcAddi   = 4'h1;
    localparam logic [3:0] OpcLw     = 4'h2;
    localparam logic [3:0] OpcSw     = 4'h3;
    localparam logic [3:0] OpcBr     = 4'h4;
    localparam logic [2:0] FunctNop  = 3'b000;
    localparam logic [2:0] FunctHalt = 3'b001;

    // Branch condition from decoder select and ALU flags.
    function automatic logic branch_cond(logic [2:0] bs, logic z, logic n);
        logic taken;
        taken = 1'b0;
        case (bs)
            BsBeq:   taken = z;
            BsBne:   taken = ~z;
            BsBltz:  taken = n;
            BsBgez:  taken = ~n;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: instruction fetch, decoder control and data-memory strobe bundle.
// master = sequencer side, slave = fetch memory / decoder / data memory side.
interface cpu_sequencer_if #(
    parameter int unsigned PC_W = cpu_pkg::PcWDefault
);
    // Instruction fetch
    logic [15:0]     inst_rdata;
    logic            inst_valid;
    logic            inst_req;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    // Decoder controls for ir
    logic            ld;
    logic            mw;
    logic            md;
    logic            hlt;
    logic [2:0]      bs;
    logic [5:0]      off;
    // ALU flags
    logic            z;
    logic            n;
    // Data memory and register file strobes
    logic            dmem_ready;
    logic            rf_we;
    logic            dmem_we;
    logic            dmem_re;
    // Status
    logic            halted;
    logic [2:0]      state;

    modport master (
        input  inst_rdata, inst_valid, ld, mw, md, hlt, bs, off, z, n, dmem_ready,
        output inst_req, pc, ir, rf_we, dmem_we, dmem_re, halted, state
    );

    modport slave (
        output inst_rdata, inst_valid, ld, mw, md, hlt, bs, off, z, n, dmem_ready,
        input  inst_req, pc, ir, rf_we, dmem_we, dmem_re, halted, state
    );

endinterface

// File: rtl/branch_unit.sv
// branch_unit: combinational branch decision and target (pc + 1 + sign-extended offset).
module branch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W = PcWDefault
) (
    input  logic [2:0]      bs,
    input  logic            z,
    input  logic            n,
    input  logic [OffW-1:0] off,
    input  logic [PC_W-1:0] pc,
    output logic            taken,
    output logic [PC_W-1:0] target
);

    // Wide enough to hold both the PC and the full offset; the sum wraps modulo 2^PC_W.
    localparam int unsigned ExtW = (PC_W > OffW) ? PC_W : OffW;

    logic [ExtW-1:0] off_ext;
    logic [ExtW-1:0] sum;

    // Condition evaluation and relative target.
    always_comb begin
        off_ext = ExtW'($signed(off));
        sum     = ExtW'(pc) + ExtW'(1) + off_ext;
        taken   = branch_cond(bs, z, n);
        target  = sum[PC_W-1:0];
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB/HALT control sequencer.
// Optional feature macro SEQ_PERF_CNT_EN adds saturating instret/cycles counters.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W = PcWDefault
) (
    input  logic            clk,
    input  logic            rst_n,
    cpu_sequencer_if.master bus
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]     instret,
    output logic [15:0]     cycles
`endif
);

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  br_target;
    logic [InstW-1:0] ir_q, ir_d;
    logic             br_taken;
    // Low from reset until the first clock edge, so no fetch is requested while in reset.
    logic             started_q;

    logic inst_req;
    logic rf_we;
    logic dmem_we;
    logic dmem_re;

    branch_unit #(
        .PC_W (PC_W)
    ) u_branch_unit (
        .bs     (bus.bs),
        .z      (bus.z),
        .n      (bus.n),
        .off    (bus.off),
        .pc     (pc_q),
        .taken  (br_taken),
        .target (br_target)
    );

    assign pc_inc = pc_q + PC_W'(1);

    // State, PC and IR registers; reset abandons any fetch or data access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            pc_q      <= '0;
            ir_q      <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            started_q <= 1'b1;
        end
    end

    // Next state, PC/IR update and strobe decode; strobes depend only on state and decoder.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        inst_req = 1'b0;
        rf_we    = 1'b0;
        dmem_we  = 1'b0;
        dmem_re  = 1'b0;
        case (state_q)
            StFetch: begin
                inst_req = started_q;
                if (started_q && bus.inst_valid) begin
                    ir_d    = bus.inst_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = bus.hlt ? StHalt : StExec;
            end
            StExec: begin
                if (bus.mw || (bus.ld && bus.md)) begin
                    state_d = StMem;
                end else if (bus.ld) begin
                    state_d = StWb;
                end else begin
                    // Branches and NOPs retire here; flags only matter in this state.
                    state_d = StFetch;
                    pc_d    = br_taken ? br_target : pc_inc;
                end
            end
            StMem: begin
                // Store wins if the decoder ever raises both, keeping the strobes exclusive.
                dmem_we = bus.mw;
                dmem_re = bus.md & ~bus.mw;
                if (bus.dmem_ready) begin
                    if (bus.mw) begin
                        state_d = StFetch;
                        pc_d    = pc_inc;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                rf_we   = 1'b1;
                pc_d    = pc_inc;
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    assign bus.inst_req = inst_req;
    assign bus.pc       = pc_q;
    assign bus.ir       = ir_q;
    assign bus.rf_we    = rf_we;
    assign bus.dmem_we  = dmem_we;
    assign bus.dmem_re  = dmem_re;
    assign bus.halted   = (state_q == StHalt);
    assign bus.state    = state_q;

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] instret_q;
    logic [15:0] cycles_q;
    logic        retire;
    logic        active;

    assign retire = (state_d == StFetch) &&
                    ((state_q == StExec) || (state_q == StMem) || (state_q == StWb));
    // The idle edge that first raises inst_req after reset is not an instruction cycle.
    assign active = started_q && (state_q != StHalt);

    // Saturating retired-instruction and active-cycle counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
            cycles_q  <= '0;
        end else begin
            if (retire && (instret_q != 16'hFFFF)) begin
                instret_q <= instret_q + 16'd1;
            end
            if (active && (cycles_q != 16'hFFFF)) begin
                cycles_q <= cycles_q + 16'd1;
            end
        end
    end

    assign instret = instret_q;
    assign cycles  = cycles_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: table-driven directed bench for cpu_sequencer with a tiny decoder model.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] instret;
    logic [15:0] cycles;
`endif

    cpu_sequencer_if #(.PC_W(8)) bus ();

    cpu_sequencer #(
        .PC_W (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus)
`ifdef SEQ_PERF_CNT_EN
        ,
        .instret (instret),
        .cycles  (cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder model driven from the latched instruction.
    logic [3:0] opc;
    logic [2:0] funct;
    assign opc     = bus.ir[15:12];
    assign funct   = bus.ir[2:0];
    assign bus.ld  = (opc == OpcAddi) || (opc == OpcLw) || ((opc == OpcRtype) && (funct > FunctHalt));
    assign bus.md  = (opc == OpcLw);
    assign bus.mw  = (opc == OpcSw);
    assign bus.hlt = (opc == OpcRtype) && (funct == FunctHalt);
    assign bus.bs  = (opc == OpcBr) ? bus.ir[8:6] : BsNone;
    assign bus.off = bus.ir[5:0];

    typedef struct {
        logic [15:0] word;
        logic        z;
        logic        n;
        int          fwait;
        int          mwait;
        int          lat;
        int          rf;
        int          we;
        int          re;
        int          pc;
        logic [2:0]  st;
    } vec_t;

    vec_t vecs[20];

    localparam logic [15:0] WAddi = {OpcAddi, 12'h005};
    localparam logic [15:0] WAlu  = {OpcRtype, 9'd0, 3'b010};
    localparam logic [15:0] WNop  = {OpcRtype, 9'd0, FunctNop};
    localparam logic [15:0] WHlt  = {OpcRtype, 9'd0, FunctHalt};
    localparam logic [15:0] WLw   = {OpcLw, 12'h021};
    localparam logic [15:0] WSw   = {OpcSw, 12'h012};

    function automatic logic [15:0] br(input logic [2:0] bs, input logic [5:0] off);
        return {OpcBr, 3'b000, bs, off};
    endfunction

    function automatic vec_t mk(input logic [15:0] w, input logic z, input logic n,
                                input int fw, input int mw, input int lat, input int rf,
                                input int we, input int re, input int pc, input logic [2:0] st);
        vec_t v;
        v.word = w;  v.z = z;   v.n = n;   v.fwait = fw; v.mwait = mw;
        v.lat = lat; v.rf = rf; v.we = we; v.re = re;    v.pc = pc;  v.st = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Assert reset, check reset values, release and wait for the first fetch request.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.inst_valid = 1'b0;
        bus.dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst state", bus.state, StFetch);
        check("rst pc", bus.pc, 0);
        check("rst ir", bus.ir, 0);
        check("rst inst_req", bus.inst_req, 0);
        check("rst halted", bus.halted, 0);
        check("rst strobes", {bus.rf_we, bus.dmem_we, bus.dmem_re}, 0);
        rst_n = 1'b1;
        #1;
        check("rst inst_req pre-edge", bus.inst_req, 0);
        @(negedge clk);
        check("rst inst_req post-edge", bus.inst_req, 1);
        check("rst pc post-edge", bus.pc, 0);
    endtask

    // Run one instruction from FETCH until FETCH re-entry or HALT, counting cycles and strobes.
    task automatic run_vec(input vec_t v, input int idx);
        int         lat, rf, we, re, fw, mc;
        bit         done, bad;
        logic [2:0] st;
        lat = 0; rf = 0; we = 0; re = 0; fw = 0; mc = 0; done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            st = bus.state;
            if (st == StFetch) begin
                bus.inst_rdata = v.word;
                bus.inst_valid = (fw >= v.fwait);
                fw++;
            end else begin
                // Garbage fetch response outside FETCH must be ignored.
                bus.inst_rdata = 16'hFFFF;
                bus.inst_valid = 1'b1;
            end
            // Flags are inverted outside EXEC so only the EXEC sample can decide a branch.
            bus.z = (st == StExec) ? v.z : ~v.z;
            bus.n = (st == StExec) ? v.n : ~v.n;
            bus.dmem_ready = (st == StMem) && (mc >= v.mwait);
            if (st == StMem) mc++;
            rf += int'(bus.rf_we);
            we += int'(bus.dmem_we);
            re += int'(bus.dmem_re);
            bad = ((int'(bus.rf_we) + int'(bus.dmem_we) + int'(bus.dmem_re)) > 1) ||
                  ((bus.rf_we || bus.dmem_we || bus.dmem_re) &&
                   ((st == StFetch) || (st == StDecode) || (st == StHalt)));
            check($sformatf("v%0d strobes", idx), bad, 0);
            lat++;
            @(negedge clk);
            if ((bus.state == StHalt) || ((bus.state == StFetch) && (st != StFetch))) done = 1'b1;
        end
        bus.dmem_ready = 1'b0;
        check($sformatf("v%0d done", idx), done, 1);
        check($sformatf("v%0d latency", idx), lat, v.lat);
        check($sformatf("v%0d rf_we", idx), rf, v.rf);
        check($sformatf("v%0d dmem_we", idx), we, v.we);
        check($sformatf("v%0d dmem_re", idx), re, v.re);
        check($sformatf("v%0d pc", idx), bus.pc, v.pc);
        check($sformatf("v%0d state", idx), bus.state, v.st);
        check($sformatf("v%0d ir", idx), bus.ir, v.word);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.inst_rdata = '0;
        bus.inst_valid = 1'b0;
        bus.z = 1'b0;
        bus.n = 1'b0;
        bus.dmem_ready = 1'b0;

        //          word                  z  n  fw mw lat rf we re pc  state
        vecs[0]  = mk(WAddi,              0, 0, 0, 0, 4,  1, 0, 0, 1,   StFetch);
        vecs[1]  = mk(br(3'b000, 6'h3D),  1, 0, 0, 0, 3,  0, 0, 0, 255, StFetch);
        vecs[2]  = mk(WNop,               0, 0, 0, 0, 3,  0, 0, 0, 0,   StFetch);
        vecs[3]  = mk(WSw,                0, 0, 0, 0, 4,  0, 1, 0, 1,   StFetch);
        vecs[4]  = mk(WSw,                0, 0, 1, 2, 7,  0, 3, 0, 2,   StFetch);
        vecs[5]  = mk(WAlu,               0, 0, 0, 0, 4,  1, 0, 0, 3,   StFetch);
        vecs[6]  = mk(WLw,                0, 0, 0, 3, 8,  1, 0, 4, 4,   StFetch);
        vecs[7]  = mk(WAddi,              0, 0, 0, 0, 4,  1, 0, 0, 5,   StFetch);
        vecs[8]  = mk(br(3'b000, 6'h3E),  0, 0, 0, 0, 3,  0, 0, 0, 6,   StFetch);
        vecs[9]  = mk(br(3'b001, 6'h3E),  0, 0, 0, 0, 3,  0, 0, 0, 5,   StFetch);
        vecs[10] = mk(br(3'b000, 6'h3E),  1, 0, 0, 0, 3,  0, 0, 0, 4,   StFetch);
        vecs[11] = mk(br(3'b010, 6'h05),  0, 1, 2, 0, 5,  0, 0, 0, 10,  StFetch);
        vecs[12] = mk(br(3'b011, 6'h05),  0, 1, 0, 0, 3,  0, 0, 0, 11,  StFetch);
        vecs[13] = mk(br(3'b100, 6'h03),  1, 1, 0, 0, 3,  0, 0, 0, 12,  StFetch);
        vecs[14] = mk(br(3'b111, 6'h03),  0, 0, 0, 0, 3,  0, 0, 0, 13,  StFetch);
        vecs[15] = mk(br(3'b011, 6'h1F),  0, 0, 0, 0, 3,  0, 0, 0, 45,  StFetch);
        vecs[16] = mk(br(3'b010, 6'h36),  0, 0, 0, 0, 3,  0, 0, 0, 46,  StFetch);
        vecs[17] = mk(br(3'b001, 6'h36),  1, 0, 0, 0, 3,  0, 0, 0, 47,  StFetch);
        vecs[18] = mk(br(3'b010, 6'h20),  0, 1, 0, 0, 3,  0, 0, 0, 16,  StFetch);
        vecs[19] = mk(WHlt,               0, 0, 0, 0, 2,  0, 0, 0, 16,  StHalt);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            run_vec(vecs[i], i);
        end

        // HALT is absorbing: no fetch, no strobes, PC frozen, even with fetch data offered.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("halt inst_req", bus.inst_req, 0);
            check("halt halted", bus.halted, 1);
            check("halt pc", bus.pc, 16);
            check("halt state", bus.state, StHalt);
            check("halt strobes", {bus.rf_we, bus.dmem_we, bus.dmem_re}, 0);
        end

        // Reset in the middle of a stalled store.
        do_reset();
        run_vec(mk(WAddi, 0, 0, 0, 0, 4, 1, 0, 0, 1, StFetch), 100);
        bus.inst_rdata = WSw;
        bus.inst_valid = 1'b1;
        bus.dmem_ready = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (bus.state == StMem) got = 1'b1;
        end
        check("rstmem reached", got, 1);
        @(negedge clk);
        check("rstmem dmem_we before", bus.dmem_we, 1);
        check("rstmem pc before", bus.pc, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmem dmem_we", bus.dmem_we, 0);
        check("rstmem state", bus.state, StFetch);
        check("rstmem pc", bus.pc, 0);
        check("rstmem ir", bus.ir, 0);
        check("rstmem inst_req", bus.inst_req, 0);
        bus.inst_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstmem inst_req pre-edge", bus.inst_req, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rstmem after dmem_we", bus.dmem_we, 0);
            check("rstmem after state", bus.state, StFetch);
            check("rstmem after inst_req", bus.inst_req, 1);
            check("rstmem after pc", bus.pc, 0);
        end

`ifdef SEQ_PERF_CNT_EN
        // Three ADDI then HALT: 3 retired, 3*4 + 2 active cycles.
        do_reset();
        check("perf instret reset", instret, 0);
        check("perf cycles reset", cycles, 0);
        for (int i = 0; i < 3; i++) begin
            run_vec(mk(WAddi, 0, 0, 0, 0, 4, 1, 0, 0, i + 1, StFetch), 200 + i);
        end
        run_vec(mk(WHlt, 0, 0, 0, 0, 2, 0, 0, 0, 3, StHalt), 203);
        check("perf instret", instret, 3);
        check("perf cycles", cycles, 14);
        repeat (5) @(negedge clk);
        check("perf cycles frozen", cycles, 14);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, program counter width in words (instruction memory word-addressed).
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port INST_RDATA  input  16  instruction word from instruction memory.
REQ-005 SHALL have port INST_VALID  input  1  INST_RDATA valid for the current INST_REQ.
REQ-006 SHALL have port INST_REQ  output  1  fetch request, address = PC.
REQ-007 SHALL have port PC  output  PC_W  current program counter.
REQ-008 SHALL have port IR  output  16  latched instruction, drives decoder INST.
REQ-009 SHALL have ports LD, MW, MD, HLT  input  1 each  decoder controls for IR.
REQ-010 SHALL have ports BS  input  3 and OFF  input  6  decoder branch select and offset.
REQ-011 SHALL have ports Z, N  input  1 each  ALU zero and negative flags.
REQ-012 SHALL have port DMEM_READY  input  1  data-memory access complete.
REQ-013 SHALL have ports RF_WE, DMEM_WE, DMEM_RE  output  1 each  register write, data write, data read strobes.
REQ-014 SHALL have port HALTED  output  1  processor halted.
REQ-015 SHALL have port STATE  output  3  current FSM state, debug.

Function
REQ-016 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-017 FETCH: INST_REQ=1 held until INST_VALID=1; on that edge IR<=INST_RDATA, go DECODE; INST_VALID outside FETCH ignored.
REQ-018 DECODE: one cycle for decoder settle; if HLT=1 go HALT, else go EXEC.
REQ-019 EXEC: MW=1 or (LD=1 and MD=1) -> MEM; LD=1 and MD=0 -> WB; otherwise -> FETCH with PC update.
REQ-020 MEM: DMEM_WE=MW, DMEM_RE=MD, held until DMEM_READY=1; then load -> WB, store -> FETCH with PC+1.
REQ-021 WB: RF_WE=1 exactly one cycle, PC<=PC+1, go FETCH.
REQ-022 Branch taken: BS=000 and Z=1; BS=001 and Z=0; BS=010 and N=1; BS=011 and N=0; BS=100..111 never taken.
REQ-023 EXEC PC update: taken -> PC<=PC+1+sign-extend(OFF) modulo 2^PC_W; not taken -> PC<=PC+1; Z/N sampled in EXEC only.
REQ-024 PC SHALL wrap from 2^PC_W-1 to 0 with no flag.
REQ-025 HALT: absorbing; HALTED=1; all strobes 0; PC frozen; exit only by reset.
REQ-026 Latencies with zero memory wait: R-type/immediate 4 cycles, load 5, store 4, branch/NOP 3.
REQ-027 RF_WE, DMEM_WE, DMEM_RE SHALL be mutually exclusive and never asserted in FETCH, DECODE, HALT.

Reset
REQ-028 RST_N=0 SHALL immediately force FETCH, PC=0, IR=0, INST_REQ=0 until first post-reset edge, all strobes 0, HALTED=0.
REQ-029 Reset during MEM or FETCH wait SHALL abandon the access; no write strobe reasserted afterwards for that instruction.
REQ-030 First edge after RST_N deasserts SHALL assert INST_REQ with PC=0.

Configuration
REQ-031 Macro SEQ_PERF_CNT_EN defined: ports INSTRET output 16 and CYCLES output 16, reset to 0; INSTRET +1 on every FETCH entry from EXEC/MEM/WB; CYCLES +1 every non-HALT cycle; both saturate at 16'hFFFF.
REQ-032 Macro SEQ_PERF_CNT_EN undefined: no counters, no INSTRET/CYCLES ports; all other behaviour identical.

Structure
REQ-033 Shared package cpu_pkg SHALL hold state encodings, BS codes (BEQ=000, BNE=001, BLTZ=010, BGEZ=011, NONE=100), opcode constants, default PC_W.
REQ-034 Sub-module branch_unit SHALL compute taken and target from BS, Z, N, OFF, PC; combinational.

Verification
REQ-035 Reset then INST_VALID=1 with ADDI word -> states FETCH,DECODE,EXEC,WB; RF_WE=1 one cycle; PC 0->1.
REQ-036 Load at PC=3, DMEM_READY delayed 3 cycles -> DMEM_RE=1 for 4 cycles, then RF_WE one cycle, PC=4.
REQ-037 BEQ OFF=6'b111110 at PC=5, Z=1 -> PC=4; same with Z=0 -> PC=6.
REQ-038 PC=2^PC_W-1 executing NOP -> PC=0; opcode 0000 FUNCT=001 -> HALT, HALTED=1, INST_REQ stays 0 for 20 cycles.
REQ-039 RST_N pulsed low mid-MEM of store -> DMEM_WE drops same cycle, PC=0, FETCH next.
REQ-040 With SEQ_PERF_CNT_EN: three ADDI then halt -> INSTRET=3, CYCLES=14.
